// File: rtl/tube_hp_pkg.sv
// Shared constants and width helpers for the host-to-parasite tube FIFO.
// Used by hp_fifo_n and hp_fifo_flags.
package tube_hp_pkg;

  localparam logic HP_MODE_ONE   = 1'b1;
  localparam logic HP_MODE_BLOCK = 1'b0;

  // Stored-data reset value, replicated to WIDTH bits by the user.
  localparam logic HP_DATA_RST_BIT = 1'b0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hp_fifo_flags.sv
// Pointer/occupancy tracking and the block-mode hysteresis flag FSM for hp_fifo_n.
// Also decides which host/parasite strobes are accepted this cycle.
module hp_fifo_flags
  import tube_hp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BLOCK = 2,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             h_wr,
  input  logic             p_rd,
  input  logic             one_byte_mode,
  input  logic             flush,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             data_avail,
  output logic             full,
  output logic             block_avail
);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_READY    = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             flag_q;
  logic             one_byte;
  logic             nonempty;
  logic             rd_en;

  // READY and DRAINING are the two states in which the block handshake is open.
  assign flag_q   = (state_q == ST_READY) || (state_q == ST_DRAINING);
  assign one_byte = (one_byte_mode == HP_MODE_ONE);
  assign nonempty = (count_q != '0);

  assign full        = one_byte ? nonempty : flag_q;
  assign data_avail  = one_byte ? nonempty : flag_q;
  assign block_avail = (one_byte_mode == HP_MODE_BLOCK) && (count_q >= BLOCK_CNT);

  assign wr_en = h_wr & ~full & ~flush;
  assign rd_en = p_rd & data_avail & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Flags follow the next count every edge, so a mode switch re-evaluates them at once.
  always_comb begin
    state_d = state_q;
    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if (count_d >= BLOCK_CNT) begin
      state_d = ST_READY;
    end else if (flag_q) begin
      state_d = ST_DRAINING;
    end else begin
      state_d = ST_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/hp_fifo_n.sv
// Parametrised host-to-parasite tube FIFO with block-mode hysteresis handshake.
// Optional sticky overflow/underflow flags are built when HP_FIFO_ERR_EN is defined.
module hp_fifo_n
  import tube_hp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int BLOCK = 2,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             h_phi2,
  input  logic             h_rst,
  input  logic             h_wr,
  input  logic [WIDTH-1:0] h_data,
  input  logic             p_rd,
  input  logic             one_byte_mode,
  input  logic             flush,
  output logic [WIDTH-1:0] p_data,
  output logic             p_data_available,
  output logic             p_block_available,
  output logic             h_full,
  output logic [CNT_W-1:0] count,
  output logic             h_overflow,
  output logic             p_underflow
);

  localparam logic [WIDTH-1:0] DATA_RST = {WIDTH{HP_DATA_RST_BIT}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  hp_fifo_flags #(
    .DEPTH (DEPTH),
    .BLOCK (BLOCK)
  ) u_flags (
    .clk           (h_phi2),
    .srst          (h_rst),
    .h_wr          (h_wr),
    .p_rd          (p_rd),
    .one_byte_mode (one_byte_mode),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_ptr        (wr_ptr),
    .rd_ptr        (rd_ptr),
    .count         (count),
    .data_avail    (p_data_available),
    .full          (h_full),
    .block_avail   (p_block_available)
  );

  // Storage survives flush; only reset clears it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge h_phi2) begin
      if (h_rst) begin
        mem_q[gi] <= DATA_RST;
      end else if (wr_en && (wr_ptr == PTR_W'(gi))) begin
        mem_q[gi] <= h_data;
      end
    end
  end

  assign p_data = mem_q[rd_ptr];

`ifdef HP_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (h_wr & h_full);
      underflow_q <= underflow_q | (p_rd & ~p_data_available);
    end
  end

  assign h_overflow  = overflow_q;
  assign p_underflow = underflow_q;
`else
  assign h_overflow  = 1'b0;
  assign p_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_hp_fifo_n.sv
// Directed bench for hp_fifo_n: DUT A uses BLOCK=2, DUT B uses BLOCK=4 (both DEPTH=4).
// Error-flag expectations follow HP_FIFO_ERR_EN.
module tb_hp_fifo_n;

`ifdef HP_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       h_wr = 1'b0;
  logic [7:0] h_data = 8'h00;
  logic       p_rd = 1'b0;
  logic       mode = 1'b0;
  logic       flush = 1'b0;

  logic [7:0] pd_a, pd_b;
  logic       av_a, av_b, bl_a, bl_b, fu_a, fu_b, ov_a, ov_b, un_a, un_b;
  logic [2:0] cn_a, cn_b;

  logic [7:0] obs_data;
  logic       obs_avail, obs_block, obs_full, obs_ovf, obs_unf;
  logic [2:0] obs_count;

  int chk  = 0;
  int pass = 0;

  always #5 clk = ~clk;

  hp_fifo_n #(.WIDTH(8), .DEPTH(4), .BLOCK(2)) dut_a (
    .h_phi2(clk), .h_rst(rst), .h_wr(h_wr & ~sel), .h_data(h_data),
    .p_rd(p_rd & ~sel), .one_byte_mode(mode), .flush(flush & ~sel),
    .p_data(pd_a), .p_data_available(av_a), .p_block_available(bl_a),
    .h_full(fu_a), .count(cn_a), .h_overflow(ov_a), .p_underflow(un_a)
  );

  hp_fifo_n #(.WIDTH(8), .DEPTH(4), .BLOCK(4)) dut_b (
    .h_phi2(clk), .h_rst(rst), .h_wr(h_wr & sel), .h_data(h_data),
    .p_rd(p_rd & sel), .one_byte_mode(mode), .flush(flush & sel),
    .p_data(pd_b), .p_data_available(av_b), .p_block_available(bl_b),
    .h_full(fu_b), .count(cn_b), .h_overflow(ov_b), .p_underflow(un_b)
  );

  assign obs_data  = sel ? pd_b : pd_a;
  assign obs_avail = sel ? av_b : av_a;
  assign obs_block = sel ? bl_b : bl_a;
  assign obs_full  = sel ? fu_b : fu_a;
  assign obs_count = sel ? cn_b : cn_a;
  assign obs_ovf   = sel ? ov_b : ov_a;
  assign obs_unf   = sel ? un_b : un_a;

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    h_wr = wr; h_data = d; p_rd = rd;
    @(posedge clk); #1;
    h_wr = 1'b0; p_rd = 1'b0;
    $display("dut=%s wr=%0d d=%02h rd=%0d flush=%0d rst=%0d -> count=%0d avail=%0d full=%0d p_data=%02h",
             sel ? "B" : "A", wr, d, rd, flush, rst, obs_count, obs_avail, obs_full, obs_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; mode = 1'b0;
    do_reset();
    chk++; if (obs_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL rst_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL rst_full got=%0d exp=0", obs_full); else pass++;
    chk++; if (obs_block !== 1'b0) $display("FAIL rst_block got=%0d exp=0", obs_block); else pass++;
    chk++; if (obs_data !== 8'h00) $display("FAIL rst_data got=%02h exp=00", obs_data); else pass++;
    chk++; if (obs_ovf !== 1'b0) $display("FAIL rst_ovf got=%0d exp=0", obs_ovf); else pass++;
    chk++; if (obs_unf !== 1'b0) $display("FAIL rst_unf got=%0d exp=0", obs_unf); else pass++;
  endtask

  task automatic test_block_handshake();
    sel = 1'b0; mode = 1'b0;
    step(1'b1, 8'hA1, 1'b0);
    chk++; if (obs_count !== 3'd1) $display("FAIL blk_w1_count got=%0d exp=1", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL blk_w1_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL blk_w1_full got=%0d exp=0", obs_full); else pass++;
    step(1'b1, 8'hB2, 1'b0);
    chk++; if (obs_avail !== 1'b1) $display("FAIL blk_w2_avail got=%0d exp=1", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b1) $display("FAIL blk_w2_full got=%0d exp=1", obs_full); else pass++;
    chk++; if (obs_data !== 8'hA1) $display("FAIL blk_w2_data got=%02h exp=a1", obs_data); else pass++;
    chk++; if (obs_block !== 1'b1) $display("FAIL blk_w2_block got=%0d exp=1", obs_block); else pass++;
    step(1'b1, 8'hC3, 1'b0);
    chk++; if (obs_count !== 3'd2) $display("FAIL blk_w3_count got=%0d exp=2", obs_count); else pass++;
    chk++; if (obs_ovf !== ERR) $display("FAIL blk_w3_ovf got=%0d exp=%0d", obs_ovf, ERR); else pass++;
    step(1'b0, 8'h00, 1'b1);
    chk++; if (obs_data !== 8'hB2) $display("FAIL blk_r1_data got=%02h exp=b2", obs_data); else pass++;
    chk++; if (obs_avail !== 1'b1) $display("FAIL blk_r1_avail got=%0d exp=1", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b1) $display("FAIL blk_r1_full got=%0d exp=1", obs_full); else pass++;
    chk++; if (obs_block !== 1'b0) $display("FAIL blk_r1_block got=%0d exp=0", obs_block); else pass++;
    step(1'b0, 8'h00, 1'b1);
    chk++; if (obs_count !== 3'd0) $display("FAIL blk_r2_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL blk_r2_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL blk_r2_full got=%0d exp=0", obs_full); else pass++;
  endtask

  task automatic test_one_byte();
    sel = 1'b0; mode = 1'b1;
    do_reset();
    step(1'b1, 8'h55, 1'b0);
    chk++; if (obs_full !== 1'b1) $display("FAIL one_w1_full got=%0d exp=1", obs_full); else pass++;
    chk++; if (obs_avail !== 1'b1) $display("FAIL one_w1_avail got=%0d exp=1", obs_avail); else pass++;
    chk++; if (obs_ovf !== 1'b0) $display("FAIL one_w1_ovf got=%0d exp=0", obs_ovf); else pass++;
    step(1'b1, 8'h66, 1'b0);
    chk++; if (obs_count !== 3'd1) $display("FAIL one_w2_count got=%0d exp=1", obs_count); else pass++;
    chk++; if (obs_ovf !== ERR) $display("FAIL one_w2_ovf got=%0d exp=%0d", obs_ovf, ERR); else pass++;
    chk++; if (obs_data !== 8'h55) $display("FAIL one_head_data got=%02h exp=55", obs_data); else pass++;
    step(1'b0, 8'h00, 1'b1);
    chk++; if (obs_count !== 3'd0) $display("FAIL one_r_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL one_r_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_unf !== 1'b0) $display("FAIL one_r_unf got=%0d exp=0", obs_unf); else pass++;
    step(1'b0, 8'h00, 1'b1);
    chk++; if (obs_count !== 3'd0) $display("FAIL one_ur_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_unf !== ERR) $display("FAIL one_ur_unf got=%0d exp=%0d", obs_unf, ERR); else pass++;
  endtask

  task automatic test_read_write_same();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    sel = 1'b1; mode = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0);
    chk++; if (obs_count !== 3'd4) $display("FAIL rw_fill_count got=%0d exp=4", obs_count); else pass++;
    chk++; if (obs_full !== 1'b1) $display("FAIL rw_fill_full got=%0d exp=1", obs_full); else pass++;
    chk++; if (obs_block !== 1'b1) $display("FAIL rw_fill_block got=%0d exp=1", obs_block); else pass++;
    // Read is accepted (avail=1) but the write is refused (full=1): net one pop.
    step(1'b1, 8'h77, 1'b1);
    chk++; if (obs_count !== 3'd3) $display("FAIL rw_same_count got=%0d exp=3", obs_count); else pass++;
    chk++; if (obs_full !== 1'b1) $display("FAIL rw_same_full got=%0d exp=1", obs_full); else pass++;
    for (int i = 1; i < 4; i++) begin
      chk++; if (obs_data !== vals[i]) $display("FAIL rw_drain_data%0d got=%02h exp=%02h", i, obs_data, vals[i]); else pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    chk++; if (obs_count !== 3'd0) $display("FAIL rw_drain_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL rw_drain_avail got=%0d exp=0", obs_avail); else pass++;
  endtask

  task automatic test_flush_and_reset();
    sel = 1'b1; mode = 1'b0;
    do_reset();
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h23, 1'b0);
    chk++; if (obs_count !== 3'd3) $display("FAIL fl_fill_count got=%0d exp=3", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL fl_fill_avail got=%0d exp=0", obs_avail); else pass++;
    flush = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    flush = 1'b0;
    chk++; if (obs_count !== 3'd0) $display("FAIL fl_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL fl_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL fl_full got=%0d exp=0", obs_full); else pass++;
    chk++; if (obs_data !== 8'h21) $display("FAIL fl_kept_data got=%02h exp=21", obs_data); else pass++;
    step(1'b1, 8'h99, 1'b0);
    chk++; if (obs_data !== 8'h99) $display("FAIL fl_ptr_data got=%02h exp=99", obs_data); else pass++;
    chk++; if (obs_count !== 3'd1) $display("FAIL fl_ptr_count got=%0d exp=1", obs_count); else pass++;
    step(1'b1, 8'h9A, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h9B, 1'b0);
    rst = 1'b0;
    chk++; if (obs_count !== 3'd0) $display("FAIL hr_count got=%0d exp=0", obs_count); else pass++;
    chk++; if (obs_avail !== 1'b0) $display("FAIL hr_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL hr_full got=%0d exp=0", obs_full); else pass++;
    chk++; if (obs_data !== 8'h00) $display("FAIL hr_data got=%02h exp=00", obs_data); else pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    sel = 1'b0; mode = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = 8'h30 + 8'(i);
      step(1'b1, d, 1'b0);
      chk++; if (obs_data !== d) $display("FAIL wrap_data%0d got=%02h exp=%02h", i, obs_data, d); else pass++;
      step(1'b0, 8'h00, 1'b1);
      chk++; if (obs_count !== 3'd0) $display("FAIL wrap_count%0d got=%0d exp=0", i, obs_count); else pass++;
    end
  endtask

  task automatic test_mode_change();
    sel = 1'b0; mode = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    mode = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk++; if (obs_avail !== 1'b0) $display("FAIL mc_avail got=%0d exp=0", obs_avail); else pass++;
    chk++; if (obs_full !== 1'b0) $display("FAIL mc_full got=%0d exp=0", obs_full); else pass++;
    step(1'b1, 8'h5B, 1'b0);
    chk++; if (obs_avail !== 1'b1) $display("FAIL mc_w_avail got=%0d exp=1", obs_avail); else pass++;
    chk++; if (obs_data !== 8'h5A) $display("FAIL mc_w_data got=%02h exp=5a", obs_data); else pass++;
  endtask

  initial begin
    test_reset();
    test_block_handshake();
    test_one_byte();
    test_read_write_same();
    test_flush_and_reset();
    test_wrap();
    test_mode_change();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
